// File: rtl/bridge_mailbox_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : bridge_mailbox_responder_if
// Description : Bridge strobe bus, core command mailbox and status signals
//               for the APF bridge target-side responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface bridge_mailbox_responder_if #(
    parameter int num_regs = 8
) ();
    logic [31:0]             addr;
    logic                    wr;
    logic                    rd;
    logic [31:0]             wr_data;
    logic [31:0]             rd_data;
    logic [32*num_regs-1:0]  regs_out;
    logic [num_regs-1:0]     reg_wr_pulse;
    logic                    cmd_valid;
    logic [31:0]             cmd_data;
    logic                    cmd_ready;
    logic [31:0]             status_in;

    // Bridge/core side: drives strobes, handshake ready and status.
    modport master (
        output addr, wr, rd, wr_data, cmd_ready, status_in,
        input  rd_data, regs_out, reg_wr_pulse, cmd_valid, cmd_data
    );

    // Responder side.
    modport slave (
        input  addr, wr, rd, wr_data, cmd_ready, status_in,
        output rd_data, regs_out, reg_wr_pulse, cmd_valid, cmd_data
    );
endinterface
`default_nettype wire

// File: rtl/bridge_mailbox_responder.sv
`default_nettype none
// ============================================================================
// Module      : bridge_mailbox_responder
// Description : Decodes bridge wr/rd strobes into a control register bank,
//               a CMD mailbox with valid/ready handshake, and a STATUS word.
//               Read data is registered and held between read hits.
// Revision    : 1.0 - initial release
// ============================================================================
module bridge_mailbox_responder #(
    parameter logic [31:0] base_addr = 32'h0000_0000,
    parameter int          num_regs  = 8
) (
    input  wire                          clk,
    input  wire                          reset,
    bridge_mailbox_responder_if.slave    bus
);
    localparam int                 c_idx_w    = $clog2(num_regs);
    localparam int                 c_off_w    = c_idx_w + 1;
    localparam logic [31:0]        c_win_mask = 32'(8 * num_regs - 1);
    localparam logic [c_off_w-1:0] c_cmd_off  = c_off_w'(num_regs);
    localparam logic [c_off_w-1:0] c_stat_off = c_off_w'(num_regs + 1);

    logic [32*num_regs-1:0] r_regs;
    logic [num_regs-1:0]    r_pulse;
    logic                   r_cmd_valid;
    logic [31:0]            r_cmd_data;
    logic                   r_overflow;
    logic [31:0]            r_rd_data;

    logic                   w_hit;
    logic [c_off_w-1:0]     w_off;
    logic [c_idx_w-1:0]     w_idx;
    logic                   w_reg_wr;
    logic                   w_hs;
    logic                   w_cmd_wr;
    logic                   w_cmd_accept;
    logic                   w_ovf_set;
    logic                   w_ovf_clr;
    logic [31:0]            w_rd_mux;
    logic                   w_unused_status;

    // Window decode; the top offset bit separates registers from CMD/STATUS.
    assign w_hit    = ((bus.addr & ~c_win_mask) == base_addr);
    assign w_off    = bus.addr[2 +: c_off_w];
    assign w_idx    = w_off[c_idx_w-1:0];
    assign w_reg_wr = bus.wr & w_hit & ~w_off[c_off_w-1];

    // A CMD write coinciding with the handshake replaces the departing word.
    assign w_hs         = r_cmd_valid & bus.cmd_ready;
    assign w_cmd_wr     = bus.wr & w_hit & (w_off == c_cmd_off);
    assign w_cmd_accept = w_cmd_wr & (~r_cmd_valid | w_hs);
    assign w_ovf_set    = w_cmd_wr & r_cmd_valid & ~w_hs;
    assign w_ovf_clr    = bus.wr & w_hit & (w_off == c_stat_off) & bus.wr_data[1];

    // Only the low 24 status bits are reported.
    assign w_unused_status = &{1'b0, bus.status_in[31:24]};

    // Read source selection from pre-write state.
    always_comb begin
        w_rd_mux = '0;
        if (!w_off[c_off_w-1]) begin
            w_rd_mux = r_regs[32*w_idx +: 32];
        end else if (w_off == c_cmd_off) begin
            w_rd_mux = r_cmd_data;
        end else if (w_off == c_stat_off) begin
            w_rd_mux = {bus.status_in[23:0], 6'b0, r_overflow, r_cmd_valid};
        end
    end

    // Control register bank and its one-cycle write pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_regs  <= '0;
            r_pulse <= '0;
        end else begin
            r_pulse <= '0;
            if (w_reg_wr) begin
                r_regs[32*w_idx +: 32] <= bus.wr_data;
                r_pulse[w_idx]         <= 1'b1;
            end
        end
    end

    // Command mailbox and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd_valid <= 1'b0;
            r_cmd_data  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_cmd_accept) begin
                r_cmd_valid <= 1'b1;
                r_cmd_data  <= bus.wr_data;
            end else if (w_hs) begin
                r_cmd_valid <= 1'b0;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Read data updates only on a read hit so the crossing sees one change per read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (bus.rd && w_hit) begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign bus.rd_data      = r_rd_data;
    assign bus.regs_out     = r_regs;
    assign bus.reg_wr_pulse = r_pulse;
    assign bus.cmd_valid    = r_cmd_valid;
    assign bus.cmd_data     = r_cmd_data;
endmodule
`default_nettype wire

// File: tb/tb_bridge_mailbox_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bridge_mailbox_responder
// Description : Self-checking bench: directed vector table, randomized
//               traffic against a transaction-level model, async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bridge_mailbox_responder;
    localparam logic [31:0] B = 32'h0000_0100;
    localparam int          N = 8;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    bridge_mailbox_responder_if #(.num_regs(N)) bus ();

    bridge_mailbox_responder #(.base_addr(B), .num_regs(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ready;
        logic [31:0] status;
        logic [31:0] exp_rd;
        logic        exp_valid;
        logic [31:0] exp_cmd;
        logic [31:0] exp_reg3;
        logic [7:0]  exp_pulse;
    } vec_t;

    vec_t vecs[$];

    // Model state
    logic [31:0] m_regs [N];
    logic        m_valid;
    logic [31:0] m_cmd;
    logic        m_ovf;
    logic [31:0] m_rd;
    logic [7:0]  m_pulse;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic add(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                       input logic rdy, input logic [31:0] st, input logic [31:0] erd,
                       input logic ev, input logic [31:0] ec, input logic [31:0] er3,
                       input logic [7:0] ep);
        vec_t v;
        v.wr = w; v.rd = r; v.addr = a; v.wdata = d; v.ready = rdy; v.status = st;
        v.exp_rd = erd; v.exp_valid = ev; v.exp_cmd = ec; v.exp_reg3 = er3; v.exp_pulse = ep;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                         input logic rdy, input logic [31:0] st);
        bus.wr = w; bus.rd = r; bus.addr = a; bus.wr_data = d;
        bus.cmd_ready = rdy; bus.status_in = st;
    endtask

    // Transaction-level reference: one bus cycle applied to the model.
    task automatic model_step(input logic w, input logic r, input logic [31:0] a,
                              input logic [31:0] d, input logic rdy, input logic [31:0] st);
        logic        hit;
        int          off;
        logic        nv;
        logic        no;
        logic [31:0] nc;
        hit = (a >= B) && (a < B + 32'd64);
        off = hit ? int'((a - B) >> 2) : -1;
        if (r && hit) begin
            if (off < N)          m_rd = m_regs[off];
            else if (off == N)    m_rd = m_cmd;
            else if (off == N+1)  m_rd = {st[23:0], 6'b0, m_ovf, m_valid};
            else                  m_rd = 32'h0;
        end
        m_pulse = '0;
        nv = m_valid; nc = m_cmd; no = m_ovf;
        if (m_valid && rdy) nv = 1'b0;
        if (w && hit) begin
            if (off < N) begin
                m_regs[off]  = d;
                m_pulse[off] = 1'b1;
            end else if (off == N) begin
                if (!m_valid || rdy) begin nv = 1'b1; nc = d; end
                else no = 1'b1;
            end else if (off == N+1 && d[1]) begin
                no = 1'b0;
            end
        end
        m_valid = nv; m_cmd = nc; m_ovf = no;
    endtask

    function automatic logic [255:0] model_regs();
        logic [255:0] p;
        for (int i = 0; i < N; i++) p[32*i +: 32] = m_regs[i];
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = '0;
        m_valid = 0; m_cmd = 0; m_ovf = 0; m_rd = 0; m_pulse = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_data"},   bus.rd_data,      0);
        check({tag, "_regs_out"},  bus.regs_out,     0);
        check({tag, "_pulse"},     bus.reg_wr_pulse, 0);
        check({tag, "_cmd_valid"}, bus.cmd_valid,    0);
        check({tag, "_cmd_data"},  bus.cmd_data,     0);
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        reset = 1'b1;
        drive(0, 0, 32'h0, 32'h0, 0, 32'h00AB_CDEF);
        model_reset();

        // Directed vectors (outputs sampled one cycle after the strobe)
        add(0,1, B+0,  0,            0, 32'h00AB_CDEF, 32'h0,         0, 32'h0,  32'h0,         8'h00);
        add(0,1, B+32, 0,            0, 32'h00AB_CDEF, 32'h0,         0, 32'h0,  32'h0,         8'h00);
        add(0,1, B+36, 0,            0, 32'h00AB_CDEF, 32'hABCD_EF00, 0, 32'h0,  32'h0,         8'h00);
        add(1,0, B+12, 32'h1234_5678,0, 32'h00AB_CDEF, 32'hABCD_EF00, 0, 32'h0,  32'h1234_5678, 8'h08);
        add(0,0, B+12, 0,            0, 32'h00AB_CDEF, 32'hABCD_EF00, 0, 32'h0,  32'h1234_5678, 8'h00);
        add(0,1, B+12, 0,            0, 32'h00AB_CDEF, 32'h1234_5678, 0, 32'h0,  32'h1234_5678, 8'h00);
        add(1,0, B+64, 32'hFFFF_FFFF,0, 32'h00AB_CDEF, 32'h1234_5678, 0, 32'h0,  32'h1234_5678, 8'h00);
        add(0,1, B+64, 0,            0, 32'h00AB_CDEF, 32'h1234_5678, 0, 32'h0,  32'h1234_5678, 8'h00);
        add(0,1, B+40, 0,            0, 32'h00AB_CDEF, 32'h0,         0, 32'h0,  32'h1234_5678, 8'h00);
        add(1,0, B+32, 32'hA5,       0, 32'h0,         32'h0,         1, 32'hA5, 32'h1234_5678, 8'h00);
        add(1,0, B+32, 32'h5A,       0, 32'h0,         32'h0,         1, 32'hA5, 32'h1234_5678, 8'h00);
        add(0,1, B+36, 0,            0, 32'h0,         32'h3,         1, 32'hA5, 32'h1234_5678, 8'h00);
        add(1,0, B+36, 32'h2,        0, 32'h0,         32'h3,         1, 32'hA5, 32'h1234_5678, 8'h00);
        add(0,1, B+36, 0,            0, 32'h0,         32'h1,         1, 32'hA5, 32'h1234_5678, 8'h00);
        add(0,0, B+0,  0,            1, 32'h0,         32'h1,         0, 32'hA5, 32'h1234_5678, 8'h00);
        add(1,0, B+32, 32'h11,       0, 32'h0,         32'h1,         1, 32'h11, 32'h1234_5678, 8'h00);
        add(1,0, B+32, 32'h22,       1, 32'h0,         32'h1,         1, 32'h22, 32'h1234_5678, 8'h00);
        add(0,1, B+36, 0,            0, 32'h0,         32'h1,         1, 32'h22, 32'h1234_5678, 8'h00);

        // Outputs during reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        foreach (vecs[k]) begin
            drive(vecs[k].wr, vecs[k].rd, vecs[k].addr, vecs[k].wdata, vecs[k].ready, vecs[k].status);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_rd_data", k),   bus.rd_data,      vecs[k].exp_rd);
            check($sformatf("v%0d_cmd_valid", k), bus.cmd_valid,    vecs[k].exp_valid);
            check($sformatf("v%0d_cmd_data", k),  bus.cmd_data,     vecs[k].exp_cmd);
            check($sformatf("v%0d_regs_out", k),  bus.regs_out,     256'(vecs[k].exp_reg3) << 96);
            check($sformatf("v%0d_pulse", k),     bus.reg_wr_pulse, vecs[k].exp_pulse);
        end

        // Fresh start for randomized traffic
        drive(0, 0, 32'h0, 32'h0, 0, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        for (int c = 0; c < 400; c++) begin
            logic        w, r, rdy;
            logic [31:0] a, d, st;
            int          sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 3)      a = B + 32'd4 * (32'd8 + $urandom_range(0, 1)) + $urandom_range(0, 3);
            else if (sel < 8) a = B + 32'd4 * $urandom_range(0, 15) + $urandom_range(0, 3);
            else if (sel == 8) a = B + 32'd64 + 32'd4 * $urandom_range(0, 15);
            else              a = $urandom;
            w   = ($urandom_range(0, 1) == 1);
            r   = ($urandom_range(0, 1) == 1);
            rdy = ($urandom_range(0, 2) == 0);
            d   = $urandom;
            st  = $urandom;
            drive(w, r, a, d, rdy, st);
            model_step(w, r, a, d, rdy, st);
            @(posedge clk);
            @(negedge clk);
            check("rnd_rd_data",   bus.rd_data,      m_rd);
            check("rnd_cmd_valid", bus.cmd_valid,    m_valid);
            check("rnd_cmd_data",  bus.cmd_data,     m_cmd);
            check("rnd_regs_out",  bus.regs_out,     model_regs());
            check("rnd_pulse",     bus.reg_wr_pulse, m_pulse);
        end

        // Async reset mid-command, between clock edges
        drive(1, 0, B+20, 32'hDEAD_BEEF, 0, 32'h0);
        @(posedge clk); @(negedge clk);
        drive(1, 0, B+32, 32'h77, 0, 32'h0);
        @(posedge clk); @(negedge clk);
        drive(0, 1, B+20, 32'h0, 0, 32'h0);
        @(posedge clk); @(negedge clk);
        drive(0, 0, B+0, 32'h0, 0, 32'h0);
        check("pre_areset_cmd_valid", bus.cmd_valid, 1'b1);
        check("pre_areset_rd_data",   bus.rd_data,   32'hDEAD_BEEF);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_all_zero("areset");
        #10 reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bridge_mailbox_responder.md
# bridge_mailbox_responder

Target-side responder for the APF bridge: it sits on the core-clock output of the bridge clock-domain crossing, in the same domain as the core, and decodes the bridge's single-cycle `wr`/`rd` strobes into a bank of control registers. It also provides a command mailbox with a valid/ready handshake to core logic, and a status word read back to the host. Read data is registered and held stable between reads, so the crossing's change-detect return path forwards each read result exactly once.

## Interface
Parameters:
- `base_addr`, default 32'h0000_0000: byte base of the window; must be aligned to the window size (8*`num_regs` bytes).
- `num_regs`, default 8: number of control registers; power of two, 2..64.

Ports:
- `clk`  in  1  core clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `addr`  in  32  bridge byte address, valid with `wr`/`rd`.
- `wr`  in  1  single-cycle write strobe.
- `rd`  in  1  single-cycle read strobe.
- `wr_data`  in  32  write data, valid with `wr`.
- `rd_data`  out  32  registered read data.
- `regs_out`  out  32*`num_regs`  control register contents; register i is at bits [32*i +: 32].
- `reg_wr_pulse`  out  `num_regs`  one-cycle pulse per register, high in the cycle its new value appears.
- `cmd_valid`  out  1  command pending for the core.
- `cmd_data`  out  32  command word; stable while `cmd_valid`=1.
- `cmd_ready`  in  1  core accepts the command.
- `status_in`  in  32  core status; bits [23:0] are reported.

## Operation
- Hit: (`addr` & ~(8*`num_regs`-1)) == `base_addr`. Word offset = `addr`[2 +: log2(`num_regs`)+1]. `addr`[1:0] are ignored.
- Offsets 0..`num_regs`-1 map to the control registers (read/write).
- Offset `num_regs` is CMD:
  - Write with `cmd_valid`=0 loads `cmd_data` and sets `cmd_valid`.
  - Write with `cmd_valid`=1 and no handshake that cycle is dropped and sets the sticky `overflow` flag.
  - A read returns `cmd_data`.
- Offset `num_regs`+1 is STATUS:
  - Read layout: [0]=`cmd_valid`, [1]=`overflow`, [7:2]=0, [31:8]=`status_in`[23:0].
  - A write with `wr_data`[1]=1 clears `overflow`.
- Other offsets in the window: reads return 0; writes are ignored.
- Misses: no state changes, and `rd_data` holds its previous value.
- Handshake: `cmd_valid` falls the cycle after a cycle with `cmd_valid`=1 and `cmd_ready`=1.
  - A CMD write in that same cycle is accepted, not counted as overflow: `cmd_valid` stays 1 and `cmd_data` takes the new word.
- Overflow set and clear in the same cycle cannot come from the bus, since one write is either CMD or STATUS.
- `wr` and `rd` in the same cycle: the write is applied and the read returns the pre-write value.
- Reset (async assert, deassert synchronous to `clk`) sets every output and internal register to 0: `rd_data`, `regs_out`, `reg_wr_pulse`, `cmd_valid`, `cmd_data`, `overflow`.

## Timing
- Register write: on `wr` at edge N, `regs_out` and `reg_wr_pulse[i]` update at edge N+1; the pulse lasts exactly one cycle.
- Read: `rd` sampled at edge N, `rd_data` valid after edge N+1 and held until the next read hit.
- CMD write at edge N: `cmd_valid`=1 and `cmd_data` valid after edge N+1.
- A STATUS read at edge N reflects state sampled at edge N (pre-update).
- Back-to-back strobes on consecutive cycles are fully supported; there are no wait states.
- The responder has no backpressure to the bridge. A dropped CMD write is reported only through `overflow`.
- Reset asserted mid-handshake clears `cmd_valid` immediately, with no clock required. A pending command is lost.

## Test plan
- Reset, then read offsets 0, `num_regs`, and `num_regs`+1 with `status_in`=32'h00AB_CDEF -> 0, 0, and 32'hABCD_EF00; all outputs are 0 during reset.
- Write 32'h1234_5678 to reg 3 (`base_addr`+12) -> `regs_out` reg 3 = 32'h1234_5678 and `reg_wr_pulse`=8'b0000_1000 for exactly one cycle, one cycle after `wr`; read back -> 32'h1234_5678 one cycle after `rd`.
- Write to `base_addr`+64 (outside an 8-register window) and read it -> no register change and `rd_data` unchanged from the prior read; read offset `num_regs`+2 -> 0.
- CMD write 32'hA5 with `cmd_ready`=0 -> `cmd_valid`=1 and `cmd_data`=32'hA5. A second CMD write 32'h5A -> dropped, STATUS = 32'h3. STATUS write 32'h2 -> STATUS = 32'h1. Raise `cmd_ready` -> `cmd_valid`=0 next cycle.
- CMD write in the same cycle as the `cmd_valid`&&`cmd_ready` handshake -> `cmd_valid` stays 1, `cmd_data` holds the new word, `overflow` stays 0.
- Assert `reset` asynchronously mid-command, between clock edges -> `cmd_valid`, `regs_out`, and `rd_data` go to 0 before the next `clk` edge.
